uart_regfile_dump: RTL and testbench
====================================

# uart_regfile_dump

Parametrised UART-side register file and state-dump engine for the narvie debug loop. Assembles an instruction from a UART receive byte stream, steps the processor core for a fixed number of clock-enable pulses (instruction on the first, NOP on the rest), and owns the core's register file. It then streams a framed, checksummed register dump to a UART transmitter, either full or delta (only registers written since the last dump).

## Interface
- XLEN, 32: register and instruction width; multiple of 8, 8..64.
- NREGS, 32: register count; power of two, 2..128; r0 reads zero.
- EXEC_CYCLES, 4: proc_en pulses per instruction, ≥1.
- NOP, 32'h00000013: instruction driven when not executing (zero-extended to XLEN).
- DELTA, 0: 0 = full dump, 1 = delta dump.
- SOF, 8'hA5: start-of-frame byte.

Ports:
- clk12  in  1  sole clock.
- rstn  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte.
- proc_en  out  1  core clock enable.
- inst_out  out  XLEN  instruction to core.
- wr_en  in  1  core regfile write.
- wr_addr  in  log2(NREGS)  write index.
- wr_data  in  XLEN  write data.
- rd_addr0, rd_addr1  in  log2(NREGS)  read indices.
- rd_data0, rd_data1  out  XLEN  registered read data.
- busy  out  1  high outside IDLE.

## Operation
- States: IDLE, EXEC, HDR, CNT, IDX, DATA, CSUM.
- IDLE: each rx_valid byte is shifted in, LSB first. After XLEN/8 bytes the word latches, the byte counter clears, and the state moves to EXEC. rx_valid outside IDLE: byte dropped, counter untouched.
- EXEC: proc_en high for exactly EXEC_CYCLES consecutive cycles. inst_out = latched word in the first of these cycles, NOP in every other cycle and every other state. Then HDR.
- Regfile: writes and read-port updates occur only in cycles with proc_en=1. wr_addr=0 is ignored. Read-during-write returns the old value. rd_data to index 0 is always 0.
- Dirty bits (DELTA=1): set on every accepted write, addr≠0. A register's bit clears when its last data byte is accepted. A write in the same cycle re-sets the bit (write wins).
- Frame:
  - SOF.
  - Count byte: NREGS in full mode; popcount of dirty bits at HDR entry in delta mode.
  - Per register, ascending index: IDX byte (delta only, index value), then XLEN/8 data bytes, LSB first. Full mode includes r0 (zeros). Delta mode skips clean registers, scanning one index per cycle.
  - CSUM: XOR of every byte after SOF up to and including the last data byte. Then IDLE.
- Delta mode with no dirty registers: frame is A5 00 00.
- A register's data is snapshotted when its first byte is presented.

## Timing
- Reset values: tx_valid=0, tx_data=0, proc_en=0, inst_out=NOP, rd_data0/1=0, busy=0, state IDLE, byte counter 0, dirty bits 0. Regfile array is not reset.
- Reset asserted mid-frame: tx_valid drops asynchronously and no partial frame resumes.
- Last instruction byte at cycle T: proc_en high during T+1..T+EXEC_CYCLES.
- SOF: tx_valid high at T+EXEC_CYCLES+1.
- Handshake: a byte transfers when tx_valid&tx_ready. tx_data and tx_valid hold stable until then. With tx_ready held high, one byte per cycle; delta mode inserts scan cycles for skipped indices.
- Full-mode frame length: 3 + NREGS·XLEN/8 bytes.

## Structure
- Package uart_regfile_pkg: state enum, default SOF and NOP constants, and a byte-count function XLEN/8.
- Sub-module uart_word_rx: byte-to-word assembler with its own counter.
- Regfile, dirty bits, exec counter and dump FSM live in the top module.

## Test plan
- Reset, then bytes 13 05 10 00 (addi x10,x0,1), core writes r10=1 on the first proc_en -> proc_en high exactly 4 cycles, inst_out=00100513 only in the first. Full frame: A5 20, 32×4 data bytes with r10 = 01 00 00 00, then the correct XOR.
- DELTA=1, core writes r3=DEADBEEF and r0=FFFFFFFF -> frame A5 01 03 EF BE AD DE, checksum 01^03^EF^BE^AD^DE.
- DELTA=1, second instruction with no writes -> A5 00 00.
- tx_ready low for 20 cycles after SOF -> tx_data stays A5; frame completes intact afterwards.
- rx bytes during DATA -> dropped; the next four bytes in IDLE form the instruction.
- rstn pulse mid-DATA -> tx_valid 0 immediately, busy 0; the next instruction produces a complete new frame.

Source files
------------

// File: rtl/uart_regfile_pkg.sv
// Shared FSM encodings, default SOF/NOP bytes and word-size helper for the
// narvie UART register-file dump engine.
package uart_regfile_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_CNT  = 3'd3;
  localparam logic [2:0] ST_IDX  = 3'd4;
  localparam logic [2:0] ST_DATA = 3'd5;
  localparam logic [2:0] ST_CSUM = 3'd6;

  localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  function automatic int unsigned word_bytes(input int unsigned xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/uart_word_rx.sv
// Byte-to-word assembler, LSB byte first; word_vld is combinational with the
// final byte. Bytes offered while en is low are ignored and the count holds.
module uart_word_rx
  import uart_regfile_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk12,
  input  logic            rstn,
  input  logic            en,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            word_vld,
  output logic [XLEN-1:0] word_dat
);

  localparam int unsigned   NB       = word_bytes(XLEN);
  localparam int unsigned   CW       = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] sr_q, sr_d;
  logic            take;

  always_comb begin
    take     = en & rx_valid;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    word_vld = take && (cnt_q == CNT_LAST);
    if (take) begin
      // new byte enters at the top so the first byte ends up in bits [7:0]
      sr_d  = (XLEN'(rx_data) << (XLEN - 8)) | (sr_q >> 8);
      cnt_d = word_vld ? '0 : cnt_q + CW'(1);
    end
    word_dat = sr_d;
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/uart_regfile_dump.sv
// Core register file plus UART instruction loader and framed register dump;
// SOF follows the last rx byte by EXEC_CYCLES+1 cycles, tx holds while !tx_ready.
module uart_regfile_dump
  import uart_regfile_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned EXEC_CYCLES = 4,
  parameter logic [31:0] NOP         = NOP_DEFAULT,
  parameter int unsigned DELTA       = 0,
  parameter logic [7:0]  SOF         = SOF_DEFAULT
) (
  input  logic                     clk12,
  input  logic                     rstn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     proc_en,
  output logic [XLEN-1:0]          inst_out,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr0,
  input  logic [$clog2(NREGS)-1:0] rd_addr1,
  output logic [XLEN-1:0]          rd_data0,
  output logic [XLEN-1:0]          rd_data1,
  output logic                     busy
);

  localparam int unsigned    NB  = word_bytes(XLEN);
  localparam int unsigned    AW  = $clog2(NREGS);
  localparam int unsigned    BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned    ECW = $clog2(EXEC_CYCLES + 1);
  localparam logic [AW-1:0]  IDX_LAST  = AW'(NREGS - 1);
  localparam logic [BW-1:0]  BYTE_LAST = BW'(NB - 1);
  localparam logic [ECW-1:0] EXEC_LAST = ECW'(EXEC_CYCLES - 1);
  localparam logic [XLEN-1:0] NOP_X    = XLEN'(NOP);

  logic [2:0]       state_q, state_d;
  logic [ECW-1:0]   exec_q, exec_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  snap_q, snap_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [NREGS-1:0] dirty_q, dirty_d;
  logic [XLEN-1:0]  rd0_q, rd0_d, rd1_q, rd1_d;
  logic [XLEN-1:0]  rf_q [NREGS];

  logic            word_vld;
  logic [XLEN-1:0] word_dat;
  logic            rf_we;
  logic [7:0]      pop;
  logic [AW-1:0]   snap_idx;
  logic [XLEN-1:0] snap_word;
  logic [XLEN-1:0] snap_sh;
  logic [7:0]      data_byte;

  uart_word_rx #(.XLEN(XLEN)) u_word_rx (
    .clk12    (clk12),
    .rstn     (rstn),
    .en       (state_q == ST_IDLE),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  assign proc_en  = (state_q == ST_EXEC);
  assign inst_out = (proc_en && exec_q == '0) ? inst_q : NOP_X;
  assign busy     = (state_q != ST_IDLE);
  assign rf_we    = proc_en & wr_en & (wr_addr != '0);
  assign rd_data0 = rd0_q;
  assign rd_data1 = rd1_q;

  always_ff @(posedge clk12) begin
    if (rf_we) rf_q[wr_addr] <= wr_data;
  end

  // r0 is never written and the array has no reset, so index 0 is masked on every read
  always_comb begin
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (proc_en) begin
      rd0_d = (rd_addr0 == '0) ? '0 : rf_q[rd_addr0];
      rd1_d = (rd_addr1 == '0) ? '0 : rf_q[rd_addr1];
    end
    snap_idx  = (state_q == ST_DATA) ? idx_q + AW'(1) : idx_q;
    snap_word = (snap_idx == '0) ? '0 : rf_q[snap_idx];
    snap_sh   = snap_q >> {byte_q, 3'b000};
    data_byte = snap_sh[7:0];
    pop = '0;
    for (int i = 0; i < NREGS; i++) pop = pop + 8'(dirty_q[i]);
  end

  always_comb begin
    state_d  = state_q;
    exec_d   = exec_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    csum_d   = csum_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    inst_d   = inst_q;
    dirty_d  = dirty_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (word_vld) begin
          inst_d  = word_dat;
          exec_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_q == EXEC_LAST) state_d = ST_HDR;
        else                     exec_d  = exec_q + ECW'(1);
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = SOF;
        csum_d   = '0;
        cnt_d    = (DELTA != 0) ? pop : 8'(NREGS);
        idx_d    = '0;
        byte_d   = '0;
        if (tx_ready) state_d = ST_CNT;
      end
      ST_CNT: begin
        tx_valid = 1'b1;
        tx_data  = cnt_q;
        if (tx_ready) begin
          csum_d = csum_q ^ cnt_q;
          if (DELTA != 0) begin
            state_d = ST_IDX;
          end else begin
            state_d = ST_DATA;
            snap_d  = snap_word;
          end
        end
      end
      ST_IDX: begin
        // clean registers cost one silent scan cycle each
        if (dirty_q[idx_q]) begin
          tx_valid = 1'b1;
          tx_data  = 8'(idx_q);
          if (tx_ready) begin
            csum_d  = csum_q ^ 8'(idx_q);
            snap_d  = snap_word;
            byte_d  = '0;
            state_d = ST_DATA;
          end
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_CSUM;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
          csum_d = csum_q ^ data_byte;
          if (byte_q == BYTE_LAST) begin
            byte_d          = '0;
            dirty_d[idx_q]  = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_CSUM;
            end else begin
              idx_d = idx_q + AW'(1);
              if (DELTA != 0) state_d = ST_IDX;
              else            snap_d  = snap_word;
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // a write in the same cycle as the final byte keeps the register dirty
    if (rf_we) dirty_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      exec_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      inst_q  <= '0;
      dirty_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      exec_q  <= exec_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      inst_q  <= inst_d;
      dirty_q <= dirty_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule

// File: tb/tb_uart_regfile_dump.sv
// Bench for uart_regfile_dump: one full-mode and one delta-mode instance, each
// with its own reference register model and expected-byte queue.
module tb_uart_regfile_dump;

  localparam int          E   = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic       dc;
    logic [7:0] v;
  } exp_t;

  logic        clk12 = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        sel = 1'b0;
  logic        tx_ready = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr0 = '0;
  logic [4:0]  rd_addr1 = '0;

  logic        rx_valid_f, rx_valid_d;
  logic [7:0]  tx_data_f, tx_data_d;
  logic        tx_valid_f, tx_valid_d;
  logic        proc_en_f, proc_en_d;
  logic [31:0] inst_out_f, inst_out_d;
  logic [31:0] rd0_f, rd0_d, rd1_f, rd1_d;
  logic        busy_f, busy_d;

  assign rx_valid_f = rx_valid & ~sel;
  assign rx_valid_d = rx_valid & sel;

  logic        proc_en_s, tx_valid_s, busy_s;
  logic [7:0]  tx_data_s;
  logic [31:0] inst_out_s, rd0_s, rd1_s;
  assign proc_en_s  = sel ? proc_en_d  : proc_en_f;
  assign tx_valid_s = sel ? tx_valid_d : tx_valid_f;
  assign tx_data_s  = sel ? tx_data_d  : tx_data_f;
  assign busy_s     = sel ? busy_d     : busy_f;
  assign inst_out_s = sel ? inst_out_d : inst_out_f;
  assign rd0_s      = sel ? rd0_d      : rd0_f;
  assign rd1_s      = sel ? rd1_d      : rd1_f;

  uart_regfile_dump #(.DELTA(0)) u_full (
    .clk12(clk12), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid_f),
    .tx_data(tx_data_f), .tx_valid(tx_valid_f), .tx_ready(tx_ready),
    .proc_en(proc_en_f), .inst_out(inst_out_f), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd0_f), .rd_data1(rd1_f), .busy(busy_f)
  );

  uart_regfile_dump #(.DELTA(1)) u_delta (
    .clk12(clk12), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid_d),
    .tx_data(tx_data_d), .tx_valid(tx_valid_d), .tx_ready(tx_ready),
    .proc_en(proc_en_d), .inst_out(inst_out_d), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd0_d), .rd_data1(rd1_d), .busy(busy_d)
  );

  always #5 clk12 = ~clk12;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // reference state: index 0 = full instance, 1 = delta instance
  logic [31:0] mrf    [2][32];
  bit          mknown [2][32];
  bit   [31:0] mdirty = '0;
  exp_t        q_f[$];
  exp_t        q_d[$];
  logic [4:0]  wq_a[$];
  logic [31:0] wq_d[$];

  function automatic void push_exp(input int s, input logic dc, input logic [7:0] v);
    exp_t x;
    x.dc = dc;
    x.v  = v;
    if (s == 0) q_f.push_back(x);
    else        q_d.push_back(x);
  endfunction

  function automatic int qsz(input int s);
    return (s == 0) ? q_f.size() : q_d.size();
  endfunction

  task automatic push_frame(input int s);
    logic [7:0]  cs;
    logic [7:0]  bt;
    logic [31:0] w;
    bit          csdc;
    bit          known;
    int          n;
    cs   = 8'h00;
    csdc = 1'b0;
    n    = 0;
    for (int i = 0; i < 32; i++) n += (s == 1) ? int'(mdirty[i]) : 1;
    push_exp(s, 1'b0, 8'hA5);
    push_exp(s, 1'b0, 8'(n));
    cs = 8'(n);
    for (int i = 0; i < 32; i++) begin
      if (s == 0 || mdirty[i]) begin
        if (s == 1) begin
          push_exp(s, 1'b0, 8'(i));
          cs = cs ^ 8'(i);
        end
        known = (i == 0) || mknown[s][i];
        w     = (i == 0) ? 32'h0 : mrf[s][i];
        for (int b = 0; b < 4; b++) begin
          bt = w[8*b +: 8];
          push_exp(s, !known, bt);
          if (known) cs = cs ^ bt;
          else       csdc = 1'b1;
        end
      end
    end
    push_exp(s, csdc, cs);
    if (s == 1) mdirty = '0;
  endtask

  always @(negedge clk12) begin : mon_f
    exp_t e;
    if (rstn && tx_valid_f && tx_ready) begin
      if (q_f.size() == 0) begin
        check_eq("tx_f_unexpected", tx_valid_f, 0);
      end else begin
        e = q_f.pop_front();
        if (!e.dc) check_eq("tx_f_byte", tx_data_f, e.v);
      end
    end
  end

  always @(negedge clk12) begin : mon_d
    exp_t e;
    if (rstn && tx_valid_d && tx_ready) begin
      if (q_d.size() == 0) begin
        check_eq("tx_d_unexpected", tx_valid_d, 0);
      end else begin
        e = q_d.pop_front();
        if (!e.dc) check_eq("tx_d_byte", tx_data_d, e.v);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk12); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_inst(input logic [31:0] inst, input bit chk_rd, input bit stall);
    int          s;
    int          nw;
    bit          rd_ok;
    logic [31:0] old;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    s  = sel ? 1 : 0;
    wa = wq_a;
    wd = wq_d;
    wq_a.delete();
    wq_d.delete();
    nw    = wa.size();
    rd_ok = chk_rd && nw > 0 && wa[0] != 5'd0;
    old   = rd_ok ? mrf[s][wa[0]] : 32'h0;
    for (int j = 0; j < nw; j++) begin
      if (wa[j] != 5'd0) begin
        mrf[s][wa[j]]    = wd[j];
        mknown[s][wa[j]] = 1'b1;
        if (s == 1) mdirty[wa[j]] = 1'b1;
      end
    end
    push_frame(s);
    @(posedge clk12); #1;
    for (int i = 0; i < 4; i++) send_byte(inst[8*i +: 8]);
    for (int k = 0; k <= E; k++) begin
      if (k < nw) begin
        wr_en   = 1'b1;
        wr_addr = wa[k];
        wr_data = wd[k];
      end else begin
        wr_en = 1'b0;
      end
      rd_addr0 = (nw > 0) ? wa[0] : 5'd0;
      rd_addr1 = 5'd0;
      if (stall && k == E) tx_ready = 1'b0;
      @(negedge clk12);
      check_eq("proc_en", proc_en_s, (k < E) ? 1 : 0);
      check_eq("inst_out", inst_out_s, (k == 0) ? inst : NOP);
      check_eq("busy_run", busy_s, 1);
      if (k == E)           check_eq("sof_valid", tx_valid_s, 1);
      if (rd_ok && k == 1)  check_eq("rd_old", rd0_s, old);
      if (rd_ok && k == 2)  check_eq("rd_new", rd0_s, mrf[s][wa[0]]);
      if (rd_ok)            check_eq("rd_r0", rd1_s, 0);
      @(posedge clk12); #1;
    end
    wr_en = 1'b0;
    if (stall) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk12);
        check_eq("stall_data", tx_data_s, 8'hA5);
        check_eq("stall_valid", tx_valid_s, 1);
        @(posedge clk12); #1;
      end
      tx_ready = 1'b1;
    end
  endtask

  task automatic wait_idle(input int s);
    int c;
    c = 0;
    @(negedge clk12);
    while (c < 3000 && (((s == 0) ? busy_f : busy_d) || qsz(s) != 0)) begin
      @(negedge clk12);
      c++;
    end
    check_eq("idle_busy", (s == 0) ? busy_f : busy_d, 0);
    check_eq("idle_queue", qsz(s), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #12;
    check_eq("rst_tx_valid", tx_valid_f, 0);
    check_eq("rst_tx_data", tx_data_f, 0);
    check_eq("rst_proc_en", proc_en_f, 0);
    check_eq("rst_inst_out", inst_out_f, NOP);
    check_eq("rst_rd0", rd0_f, 0);
    check_eq("rst_rd1", rd1_f, 0);
    check_eq("rst_busy", busy_f, 0);
    check_eq("rst_tx_valid_d", tx_valid_d, 0);
    check_eq("rst_busy_d", busy_d, 0);
    #10;
    rstn = 1'b1;

    // bring every full-instance register to a known zero
    sel = 1'b0;
    for (int j = 0; j < 8; j++) begin
      for (int a = 4*j + 1; a <= 4*j + 4; a++) begin
        wq_a.push_back((a < 32) ? 5'(a) : 5'd0);
        wq_d.push_back(32'h0);
      end
      run_inst(NOP, 1'b0, 1'b0);
      wait_idle(0);
    end

    // addi x10,x0,1 with r10 <= 1 on the first enable
    wq_a.push_back(5'd10);
    wq_d.push_back(32'h1);
    run_inst(32'h0010_0513, 1'b1, 1'b0);
    wait_idle(0);

    // bytes offered mid-frame must be dropped without advancing the assembler
    wq_a.push_back(5'd5);
    wq_d.push_back(32'h1234_5678);
    run_inst(32'h0020_0593, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    @(negedge clk12);
    check_eq("drop_busy", busy_f, 1);
    wait_idle(0);
    run_inst(32'h0050_0613, 1'b0, 1'b0);
    wait_idle(0);

    // delta: r3 written, r0 write ignored, tx stalled after SOF
    sel = 1'b1;
    wq_a.push_back(5'd3);
    wq_d.push_back(32'hDEAD_BEEF);
    wq_a.push_back(5'd0);
    wq_d.push_back(32'hFFFF_FFFF);
    run_inst(32'h0030_0193, 1'b0, 1'b1);
    wait_idle(1);
    run_inst(32'h0000_0013, 1'b0, 1'b0);
    wait_idle(1);

    // reset in the middle of a full dump, then a fresh complete frame
    sel = 1'b0;
    run_inst(32'h0000_0013, 1'b0, 1'b0);
    repeat (20) @(posedge clk12);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("midrst_tx_valid", tx_valid_f, 0);
    check_eq("midrst_busy", busy_f, 0);
    q_f.delete();
    q_d.delete();
    mdirty = '0;
    repeat (3) @(posedge clk12);
    #1;
    rstn = 1'b1;
    @(negedge clk12);
    check_eq("postrst_tx_valid", tx_valid_f, 0);
    wq_a.push_back(5'd7);
    wq_d.push_back(32'hCAFE_F00D);
    run_inst(32'h00A0_0693, 1'b1, 1'b0);
    wait_idle(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
